// File: rtl/vex_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vex_bus_arbiter
// Purpose  : Shares one cmd/rsp memory port between the VexRiscv iBus
//            (instruction fetch) and dBus (data). Round-robin arbitration,
//            grant lock across dBus write bursts, and an in-order tag FIFO
//            that routes each read response back to the bus that issued it.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            iBus_cmd_* / iBus_rsp_* - fetch command and response
//            dBus_cmd_* / dBus_rsp_* - data command and response
//            mem_cmd_*  / mem_rsp_*  - shared memory port
//            outstanding             - reads currently in flight
//            err_unexpected          - sticky: response seen with no read pending
// Revision : 1.0 - initial release
// ============================================================================
module vex_bus_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int MAX_OUTSTAND = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          iBus_cmd_valid,
   output logic                          iBus_cmd_ready,
   input  logic [ADDR_W-1:0]             iBus_cmd_address,
   input  logic [2:0]                    iBus_cmd_size,
   output logic                          iBus_rsp_valid,
   output logic [DATA_W-1:0]             iBus_rsp_data,
   output logic                          iBus_rsp_error,
   input  logic                          dBus_cmd_valid,
   output logic                          dBus_cmd_ready,
   input  logic                          dBus_cmd_wr,
   input  logic [ADDR_W-1:0]             dBus_cmd_address,
   input  logic [DATA_W-1:0]             dBus_cmd_data,
   input  logic [DATA_W/8-1:0]           dBus_cmd_mask,
   input  logic [2:0]                    dBus_cmd_size,
   input  logic                          dBus_cmd_last,
   output logic                          dBus_rsp_valid,
   output logic [DATA_W-1:0]             dBus_rsp_data,
   output logic                          dBus_rsp_error,
   output logic                          dBus_rsp_last,
   output logic                          mem_cmd_valid,
   input  logic                          mem_cmd_ready,
   output logic                          mem_cmd_wr,
   output logic [ADDR_W-1:0]             mem_cmd_address,
   output logic [DATA_W-1:0]             mem_cmd_data,
   output logic [DATA_W/8-1:0]           mem_cmd_mask,
   output logic [2:0]                    mem_cmd_size,
   output logic                          mem_cmd_last,
   input  logic                          mem_rsp_valid,
   input  logic [DATA_W-1:0]             mem_rsp_data,
   input  logic                          mem_rsp_error,
   input  logic                          mem_rsp_last,
   output logic [$clog2(MAX_OUTSTAND):0] outstanding,
   output logic                          err_unexpected
);

   localparam int PTR_W = $clog2(MAX_OUTSTAND);
   localparam int CNT_W = PTR_W + 1;

   // Grant encoding doubles as the FIFO tag: 0 = iBus, 1 = dBus.
   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t                  state_q;
   logic                    grant_q;
   logic                    lock_q;
   logic                    rr_q;       // preferred requester on a tie
   logic [MAX_OUTSTAND-1:0] tag_q;
   logic [PTR_W-1:0]        wr_ptr_q;
   logic [PTR_W-1:0]        rd_ptr_q;
   logic [CNT_W-1:0]        count_q;

   logic pick;
   logic gnt;
   logic gnt_valid;
   logic is_read;
   logic fifo_full;
   logic fifo_empty;
   logic accept;
   logic opens_lock;
   logic push;
   logic pop;
   logic rsp_hit;
   logic head_tag;

   // In IDLE the pick is combinational so a command can win and be accepted
   // in the same cycle; in HOLD the registered grant is used.
   assign pick       = (iBus_cmd_valid & dBus_cmd_valid) ? rr_q : dBus_cmd_valid;
   assign gnt        = (state_q == S_HOLD) ? grant_q : pick;
   assign gnt_valid  = gnt ? dBus_cmd_valid : iBus_cmd_valid;
   assign is_read    = gnt ? ~dBus_cmd_wr : 1'b1;
   assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTAND));
   assign fifo_empty = (count_q == '0);

   // A read with no free tag slot is withheld from the memory port entirely.
   assign mem_cmd_valid  = gnt_valid & ~(is_read & fifo_full);
   assign accept         = mem_cmd_valid & mem_cmd_ready;
   assign iBus_cmd_ready = accept & ~gnt;
   assign dBus_cmd_ready = accept & gnt;
   assign opens_lock     = gnt & dBus_cmd_wr & ~dBus_cmd_last;

   // Payload is zeroed whenever no command is presented.
   always_comb begin
      mem_cmd_wr      = 1'b0;
      mem_cmd_address = '0;
      mem_cmd_data    = '0;
      mem_cmd_mask    = '0;
      mem_cmd_size    = '0;
      mem_cmd_last    = 1'b0;
      if (mem_cmd_valid) begin
         if (gnt) begin
            mem_cmd_wr      = dBus_cmd_wr;
            mem_cmd_address = dBus_cmd_address;
            mem_cmd_data    = dBus_cmd_data;
            mem_cmd_mask    = dBus_cmd_mask;
            mem_cmd_size    = dBus_cmd_size;
            mem_cmd_last    = dBus_cmd_last;
         end else begin
            mem_cmd_address = iBus_cmd_address;
            mem_cmd_mask    = '1;
            mem_cmd_size    = iBus_cmd_size;
            mem_cmd_last    = 1'b1;
         end
      end
   end

   // Response routing follows the oldest outstanding tag.
   assign push     = accept & is_read;
   assign head_tag = tag_q[rd_ptr_q];
   assign rsp_hit  = mem_rsp_valid & ~fifo_empty;
   assign pop      = rsp_hit & mem_rsp_last;

   assign iBus_rsp_valid = rsp_hit & ~head_tag;
   assign iBus_rsp_data  = iBus_rsp_valid ? mem_rsp_data : '0;
   assign iBus_rsp_error = iBus_rsp_valid & mem_rsp_error;
   assign dBus_rsp_valid = rsp_hit & head_tag;
   assign dBus_rsp_data  = dBus_rsp_valid ? mem_rsp_data : '0;
   assign dBus_rsp_error = dBus_rsp_valid & mem_rsp_error;
   assign dBus_rsp_last  = dBus_rsp_valid & mem_rsp_last;
   assign outstanding    = count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         grant_q        <= 1'b0;
         lock_q         <= 1'b0;
         rr_q           <= 1'b1;
         tag_q          <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         err_unexpected <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  if (opens_lock) begin
                     state_q <= S_HOLD;
                     grant_q <= 1'b1;
                     lock_q  <= 1'b1;
                  end else begin
                     rr_q <= ~gnt;
                  end
               end else if (mem_cmd_valid) begin
                  // Stalled by the memory port: freeze the grant.
                  state_q <= S_HOLD;
                  grant_q <= gnt;
               end
            end
            S_HOLD: begin
               if (accept) begin
                  if (opens_lock) begin
                     lock_q <= 1'b1;
                  end else begin
                     state_q <= S_IDLE;
                     lock_q  <= 1'b0;
                     rr_q    <= ~gnt;
                  end
               end else if (!lock_q && !gnt_valid) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase

         if (push) begin
            tag_q[wr_ptr_q] <= gnt;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end

         if (mem_rsp_valid && fifo_empty) begin
            err_unexpected <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vex_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vex_bus_arbiter
// Purpose  : Randomised self-checking bench for vex_bus_arbiter. Requesters
//            and the memory side are random; a reference model built on a
//            tag queue and the arbitration rules predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vex_bus_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int MAX_OUT = 4;
   localparam int CYCLES  = 4000;

   logic                 clk;
   logic                 reset;
   logic                 iBus_cmd_valid;
   logic                 iBus_cmd_ready;
   logic [ADDR_W-1:0]    iBus_cmd_address;
   logic [2:0]           iBus_cmd_size;
   logic                 iBus_rsp_valid;
   logic [DATA_W-1:0]    iBus_rsp_data;
   logic                 iBus_rsp_error;
   logic                 dBus_cmd_valid;
   logic                 dBus_cmd_ready;
   logic                 dBus_cmd_wr;
   logic [ADDR_W-1:0]    dBus_cmd_address;
   logic [DATA_W-1:0]    dBus_cmd_data;
   logic [DATA_W/8-1:0]  dBus_cmd_mask;
   logic [2:0]           dBus_cmd_size;
   logic                 dBus_cmd_last;
   logic                 dBus_rsp_valid;
   logic [DATA_W-1:0]    dBus_rsp_data;
   logic                 dBus_rsp_error;
   logic                 dBus_rsp_last;
   logic                 mem_cmd_valid;
   logic                 mem_cmd_ready;
   logic                 mem_cmd_wr;
   logic [ADDR_W-1:0]    mem_cmd_address;
   logic [DATA_W-1:0]    mem_cmd_data;
   logic [DATA_W/8-1:0]  mem_cmd_mask;
   logic [2:0]           mem_cmd_size;
   logic                 mem_cmd_last;
   logic                 mem_rsp_valid;
   logic [DATA_W-1:0]    mem_rsp_data;
   logic                 mem_rsp_error;
   logic                 mem_rsp_last;
   logic [$clog2(MAX_OUT):0] outstanding;
   logic                 err_unexpected;

   vex_bus_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .MAX_OUTSTAND (MAX_OUT)
   ) u_dut (
      .clk              (clk),
      .reset            (reset),
      .iBus_cmd_valid   (iBus_cmd_valid),
      .iBus_cmd_ready   (iBus_cmd_ready),
      .iBus_cmd_address (iBus_cmd_address),
      .iBus_cmd_size    (iBus_cmd_size),
      .iBus_rsp_valid   (iBus_rsp_valid),
      .iBus_rsp_data    (iBus_rsp_data),
      .iBus_rsp_error   (iBus_rsp_error),
      .dBus_cmd_valid   (dBus_cmd_valid),
      .dBus_cmd_ready   (dBus_cmd_ready),
      .dBus_cmd_wr      (dBus_cmd_wr),
      .dBus_cmd_address (dBus_cmd_address),
      .dBus_cmd_data    (dBus_cmd_data),
      .dBus_cmd_mask    (dBus_cmd_mask),
      .dBus_cmd_size    (dBus_cmd_size),
      .dBus_cmd_last    (dBus_cmd_last),
      .dBus_rsp_valid   (dBus_rsp_valid),
      .dBus_rsp_data    (dBus_rsp_data),
      .dBus_rsp_error   (dBus_rsp_error),
      .dBus_rsp_last    (dBus_rsp_last),
      .mem_cmd_valid    (mem_cmd_valid),
      .mem_cmd_ready    (mem_cmd_ready),
      .mem_cmd_wr       (mem_cmd_wr),
      .mem_cmd_address  (mem_cmd_address),
      .mem_cmd_data     (mem_cmd_data),
      .mem_cmd_mask     (mem_cmd_mask),
      .mem_cmd_size     (mem_cmd_size),
      .mem_cmd_last     (mem_cmd_last),
      .mem_rsp_valid    (mem_rsp_valid),
      .mem_rsp_data     (mem_rsp_data),
      .mem_rsp_error    (mem_rsp_error),
      .mem_rsp_last     (mem_rsp_last),
      .outstanding      (outstanding),
      .err_unexpected   (err_unexpected)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model state: tag queue of reads in flight (0=iBus, 1=dBus),
   // tie-break preference, burst lock, and a grant frozen by a stalled command.
   bit m_tags[$];
   bit m_pref;
   bit m_lock;
   bit m_hold;
   bit m_hold_g;
   bit m_err;

   // Requester state in the bench.
   bit                i_pend;
   logic [ADDR_W-1:0] i_addr;
   logic [2:0]        i_size;
   bit                d_pend;
   bit                d_wr;
   int                d_left;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_data;
   logic [3:0]        d_mask;
   logic [2:0]        d_size;

   task automatic model_reset();
      m_tags.delete();
      m_pref   = 1'b1;
      m_lock   = 1'b0;
      m_hold   = 1'b0;
      m_hold_g = 1'b0;
      m_err    = 1'b0;
      i_pend   = 1'b0;
      d_pend   = 1'b0;
      d_left   = 0;
   endtask

   task automatic drive_idle();
      iBus_cmd_valid   = 1'b0;
      iBus_cmd_address = '0;
      iBus_cmd_size    = '0;
      dBus_cmd_valid   = 1'b0;
      dBus_cmd_wr      = 1'b0;
      dBus_cmd_address = '0;
      dBus_cmd_data    = '0;
      dBus_cmd_mask    = '0;
      dBus_cmd_size    = '0;
      dBus_cmd_last    = 1'b0;
      mem_cmd_ready    = 1'b0;
      mem_rsp_valid    = 1'b0;
      mem_rsp_data     = '0;
      mem_rsp_error    = 1'b0;
      mem_rsp_last     = 1'b0;
   endtask

   initial begin
      bit g, rd, mv, acc, iv, dv, has_head, do_rst;
      int req_pct, rdy_pct, rsp_pct;

      drive_idle();
      reset = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      // Post-reset quiescent state.
      check_val("rst_mem_cmd_valid", mem_cmd_valid, 0);
      check_val("rst_mem_cmd_mask", mem_cmd_mask, 0);
      check_val("rst_iBus_cmd_ready", iBus_cmd_ready, 0);
      check_val("rst_dBus_cmd_ready", dBus_cmd_ready, 0);
      check_val("rst_iBus_rsp_valid", iBus_rsp_valid, 0);
      check_val("rst_dBus_rsp_valid", dBus_rsp_valid, 0);
      check_val("rst_outstanding", outstanding, 0);
      check_val("rst_err_unexpected", err_unexpected, 0);

      for (cyc = 0; cyc < CYCLES; cyc++) begin
         @(posedge clk);
         #1;
         case ((cyc / 250) % 3)
            0:       begin req_pct = 70; rdy_pct = 80;  rsp_pct = 5;  end
            1:       begin req_pct = 50; rdy_pct = 40;  rsp_pct = 50; end
            default: begin req_pct = 90; rdy_pct = 100; rsp_pct = 30; end
         endcase
         do_rst = ($urandom_range(0, 499) == 0);
         reset  = do_rst;

         // iBus requester: holds its command until accepted.
         if (!i_pend && ($urandom_range(0, 99) < req_pct)) begin
            i_pend = 1'b1;
            i_addr = $urandom & 32'hFFFF_FFFC;
            i_size = 3'($urandom_range(0, 5));
         end
         // dBus requester: reads are single beats, writes are 1..4 beat bursts.
         if (!d_pend) begin
            if (d_left > 0) begin
               if ($urandom_range(0, 3) != 0) begin
                  d_pend = 1'b1;
                  d_addr = d_addr + 32'd4;
                  d_data = $urandom;
                  d_mask = 4'($urandom);
               end
            end else if ($urandom_range(0, 99) < req_pct) begin
               d_pend = 1'b1;
               d_wr   = 1'($urandom);
               d_left = d_wr ? $urandom_range(1, 4) : 1;
               d_addr = $urandom & 32'hFFFF_FFFC;
               d_data = $urandom;
               d_mask = 4'($urandom);
               d_size = 3'($urandom_range(0, 2));
            end
         end
         iBus_cmd_valid   = i_pend;
         iBus_cmd_address = i_addr;
         iBus_cmd_size    = i_size;
         dBus_cmd_valid   = d_pend;
         dBus_cmd_wr      = d_wr;
         dBus_cmd_address = d_addr;
         dBus_cmd_data    = d_data;
         dBus_cmd_mask    = d_mask;
         dBus_cmd_size    = d_size;
         dBus_cmd_last    = (d_left == 1);

         mem_cmd_ready = ($urandom_range(0, 99) < rdy_pct);
         if (m_tags.size() > 0) mem_rsp_valid = ($urandom_range(0, 99) < rsp_pct);
         else                   mem_rsp_valid = ($urandom_range(0, 999) < 3);
         mem_rsp_data  = $urandom;
         mem_rsp_error = ($urandom_range(0, 9) == 0);
         mem_rsp_last  = 1'($urandom);
         #1;

         if (do_rst) begin
            model_reset();
         end else begin
            // Whose turn: locked burst, frozen stall, else tie-break/only requester.
            if (m_lock)                        g = 1'b1;
            else if (m_hold)                   g = m_hold_g;
            else if (i_pend && d_pend)         g = m_pref;
            else                               g = d_pend;
            rd  = g ? !d_wr : 1'b1;
            mv  = (g ? d_pend : i_pend) && !(rd && (m_tags.size() == MAX_OUT));
            acc = mv && mem_cmd_ready;

            check_val("mem_cmd_valid", mem_cmd_valid, mv);
            check_val("iBus_cmd_ready", iBus_cmd_ready, acc && !g);
            check_val("dBus_cmd_ready", dBus_cmd_ready, acc && g);
            check_val("outstanding", outstanding, m_tags.size());
            check_val("err_unexpected", err_unexpected, m_err);
            if (mv) begin
               check_val("mem_cmd_wr", mem_cmd_wr, g ? d_wr : 1'b0);
               check_val("mem_cmd_address", mem_cmd_address, g ? d_addr : i_addr);
               check_val("mem_cmd_size", mem_cmd_size, g ? d_size : i_size);
               check_val("mem_cmd_mask", mem_cmd_mask, g ? d_mask : 4'hF);
               check_val("mem_cmd_last", mem_cmd_last, g ? (d_left == 1) : 1'b1);
               if (g && d_wr) check_val("mem_cmd_data", mem_cmd_data, d_data);
            end

            has_head = (m_tags.size() > 0);
            iv = mem_rsp_valid && has_head && (m_tags[0] == 1'b0);
            dv = mem_rsp_valid && has_head && (m_tags[0] == 1'b1);
            check_val("iBus_rsp_valid", iBus_rsp_valid, iv);
            check_val("dBus_rsp_valid", dBus_rsp_valid, dv);
            if (iv) begin
               check_val("iBus_rsp_data", iBus_rsp_data, mem_rsp_data);
               check_val("iBus_rsp_error", iBus_rsp_error, mem_rsp_error);
            end
            if (dv) begin
               check_val("dBus_rsp_data", dBus_rsp_data, mem_rsp_data);
               check_val("dBus_rsp_error", dBus_rsp_error, mem_rsp_error);
               check_val("dBus_rsp_last", dBus_rsp_last, mem_rsp_last);
            end

            // Advance the model.
            if (mem_rsp_valid && !has_head) m_err = 1'b1;
            if (mem_rsp_valid && has_head && mem_rsp_last) void'(m_tags.pop_front());
            if (acc && rd) m_tags.push_back(g);
            if (acc) begin
               if (g && d_wr && (d_left != 1)) begin
                  m_lock = 1'b1;
               end else begin
                  m_lock = 1'b0;
                  m_pref = !g;
               end
            end
            m_hold   = mv && !mem_cmd_ready;
            m_hold_g = g;

            // Advance the requesters.
            if (acc && !g) i_pend = 1'b0;
            if (acc && g) begin
               d_pend = 1'b0;
               d_left = d_left - 1;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
